// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit that holds the architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use radix-2 restoring shift-subtract.
// Both operate on operand magnitudes, and a FIX cycle then applies the sign correction.
// Build option: define MDU_DIV_EN to build the divider.
// Without MDU_DIV_EN, op 2/3 is ignored in the same way as ops 6/7.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     mc_q;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     a_raw_q;    // unmodified dividend, needed for the divide-by-zero result
    logic                 is_div_q;
    logic                 neg_res_q;  // product/quotient must be negated
    logic                 neg_a_q;    // remainder takes the dividend's sign
    logic                 dz_q;       // divisor was zero
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 accept_s;
    logic                 op_mul_s;
    logic                 op_div_s;
    logic                 signed_op_s;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_step_d;
    logic [2*WIDTH-1:0]   div_step_d;
    logic [2*WIDTH-1:0]   acc_step_d;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     div_hi_s;
    logic [WIDTH-1:0]     div_lo_s;
    logic [WIDTH-1:0]     fix_hi_d;
    logic [WIDTH-1:0]     fix_lo_d;

    // Decode the incoming EX-stage op and form the operand magnitudes
    always_comb begin
        op_mul_s    = (op == 3'd0) || (op == 3'd1);
`ifdef MDU_DIV_EN
        op_div_s    = (op == 3'd2) || (op == 3'd3);
`else
        op_div_s    = 1'b0;
`endif
        signed_op_s = (op == 3'd0) || (op == 3'd2);
        a_neg_s     = signed_op_s & a[WIDTH-1];
        b_neg_s     = signed_op_s & b[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = {WIDTH{1'b0}} - a;
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = {WIDTH{1'b0}} - b;
        end else begin
            b_mag_s = b;
        end
        accept_s = start & ~cancel & (state_q == S_IDLE);
    end

    // One radix-2 iteration step for multiply (shift-add) and divide (restoring)
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (acc_q[0]) begin
            mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mc_q};
        end else begin
            mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end
        mul_step_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        div_step_d = acc_q;
`ifdef MDU_DIV_EN
        begin : div_step
            logic [WIDTH:0] sh_v;
            logic [WIDTH:0] try_v;
            sh_v  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
            try_v = sh_v - {1'b0, mc_q};
            if (try_v[WIDTH]) begin
                div_step_d = {sh_v[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                div_step_d = {try_v[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end
`endif
        if (is_div_q) begin
            acc_step_d = div_step_d;
        end else begin
            acc_step_d = mul_step_d;
        end
    end

    // Sign correction and special-case results applied in the FIX cycle
    always_comb begin
        if (neg_res_q) begin
            prod_s = {(2*WIDTH){1'b0}} - acc_q;
        end else begin
            prod_s = acc_q;
        end
        if (dz_q) begin
            div_lo_s = {WIDTH{1'b1}};
            div_hi_s = a_raw_q;
        end else begin
            if (neg_res_q) begin
                div_lo_s = {WIDTH{1'b0}} - acc_q[WIDTH-1:0];
            end else begin
                div_lo_s = acc_q[WIDTH-1:0];
            end
            if (neg_a_q) begin
                div_hi_s = {WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH];
            end else begin
                div_hi_s = acc_q[2*WIDTH-1:WIDTH];
            end
        end
        if (is_div_q) begin
            fix_hi_d = div_hi_s;
            fix_lo_d = div_lo_s;
        end else begin
            fix_hi_d = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_d = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM with HI/LO, iteration datapath and registered busy/done
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            mc_q      <= {WIDTH{1'b0}};
            a_raw_q   <= {WIDTH{1'b0}};
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (accept_s && (op_mul_s || op_div_s)) begin
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= {CW{1'b0}};
                        is_div_q  <= op_div_s;
                        neg_res_q <= a_neg_s ^ b_neg_s;
                        neg_a_q   <= a_neg_s;
                        a_raw_q   <= a;
                        dz_q      <= op_div_s && (b == {WIDTH{1'b0}});
                        if (op_div_s) begin
                            mc_q  <= b_mag_s;
                            acc_q <= {{WIDTH{1'b0}}, a_mag_s};
                        end else begin
                            mc_q  <= a_mag_s;
                            acc_q <= {{WIDTH{1'b0}}, b_mag_s};
                        end
                    end else if (accept_s && (op == 3'd4)) begin
                        hi_q <= a;
                    end else if (accept_s && (op == 3'd5)) begin
                        lo_q <= a;
                    end
                end
                S_RUN: begin
                    done_q <= 1'b0;
                    if (cancel) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= {CW{1'b0}};
                    end else begin
                        acc_q <= acc_step_d;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_FIX;
                            cnt_q   <= {CW{1'b0}};
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (cancel) begin
                        done_q <= 1'b0;
                    end else begin
                        hi_q   <= fix_hi_d;
                        lo_q   <= fix_lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    cnt_q   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign stall = busy_q & (start | rd_req);

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the pipelined MIPS core, holding the architectural HI/LO registers. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage, runs multi-cycle radix-2 iterations, and raises a stall request to the hazard logic while an MFHI/MFLO or a new MDU op would collide with an in-flight operation. It is parametrised in data width and supports cancellation on pipeline flush.

## Interface
- WIDTH, 32, operand/HI/LO width; legal range 4..64.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  MDU instruction valid in EX this cycle.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- a  in  WIDTH  rs operand (multiplicand, dividend, MTHI/MTLO source).
- b  in  WIDTH  rt operand (multiplier, divisor).
- rd_req  in  1  MFHI/MFLO in EX this cycle.
- cancel  in  1  abort in-flight op (exception/flush).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  MULT/DIV in progress.
- done  out  1  one-cycle pulse when HI/LO take a MULT/DIV result.
- stall  out  1  = busy & (start | rd_req); combinational.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: `start & ~cancel` with op 0..3 latches |a|, |b| (signed ops take magnitudes), sign flags, and op class; clears counter; goes to RUN. Op 4/5 writes a to HI/LO at that edge and stays IDLE. Ops 6/7 are ignored.
- RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle. The counter runs 0..WIDTH-1, then the unit goes to FIX.
- FIX: applies sign correction.
  - Product is negated if the operand signs differ (signed only).
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - HI/LO are written; done=1; the unit returns to IDLE.
- Multiply result: {HI,LO} = 2·WIDTH-bit product.
- Divide result: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = a (unsigned raw value for both ops); normal latency.
- Signed divide of −2^(WIDTH−1) by −1: LO = −2^(WIDTH−1) (wraps), HI = 0.
- start while busy is not accepted; stall=1 and the EX stage holds the instruction until busy falls.
- rd_req while busy gives stall=1. rd_req while idle gives stall=0, and hi/lo are read directly.
- cancel in RUN/FIX: returns to IDLE next edge with HI/LO unchanged and no done.
- cancel in IDLE blocks acceptance in that cycle.
- cancel in the same cycle as FIX completion: cancel wins; HI/LO are not written.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0; stall=0 follows.
- Reset mid-operation aborts it, with reset values applied at that edge.
- Edge E0 accepts a MULT/DIV.
- busy=1 from after E0 through edge E0+WIDTH+1.
- HI/LO are updated and done=1 in the cycle after edge E0+WIDTH+1, with busy=0 in that same cycle. Total latency is WIDTH+1 cycles.
- A new op can be accepted in the same cycle done is high.
- MTHI/MTLO: HI/LO are visible the cycle after acceptance.
- Back-to-back MTHI then MFHI needs no stall.

## Configuration
- MDU_DIV_EN defined: the DIV/DIVU datapath is built as described above.
- MDU_DIV_EN undefined:
  - Divider logic is omitted.
  - op 2/3 behaves as 6/7: not accepted, no busy, no done, HI/LO unchanged.
  - Multiply and MTHI/MTLO are unaffected.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF (WIDTH=32) → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, done pulse once; busy high exactly 33 cycles.
- MULT a=−3, b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 → LO=3, HI=1.
- DIVU a=0x1234, b=0 → LO=0xFFFFFFFF, HI=0x1234. DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- During MULT, assert rd_req and a second start (MULTU 2×2) → stall=1 each busy cycle. Second op accepted on the done cycle; HI=0, LO=4 after 33 more cycles.
- MTLO a=0x55 then MTHI a=0xAA on consecutive idle cycles → LO=0x55, HI=0xAA next cycles, busy never set.
- Cancel in RUN cycle 10 and in FIX → HI/LO retain prior values, no done. Reset in RUN cycle 5 → all outputs 0 next cycle. WIDTH=8 build: MULTU 0xFF×0xFF → HI=0xFE, LO=0x01 after 9 cycles.
